// File: rtl/floo_mcast_fork.sv
// Multicast fork stage: replicates each VC's flit to every output selected by
// a destination mask (locked for the whole packet) and completes the input
// handshake only once every selected output has taken the flit.
// Optional watchdog: define FLOO_MCAST_FORK_WATCHDOG_EN to flag VCs whose
// head-of-line flit stalls for WatchdogCycles cycles (sticky err_o).
module floo_mcast_fork #(
   parameter int unsigned NumOutput       = 5,
   parameter int unsigned NumVirtChannels = 2,
   parameter type         flit_t          = logic,
   parameter bit          AsyncFork       = 1'b1,
   parameter int unsigned WatchdogCycles  = 1024
) (
   input  logic                                           clk_i,
   input  logic                                           rst_ni,
   input  logic  [NumVirtChannels-1:0]                    valid_i,
   output logic  [NumVirtChannels-1:0]                    ready_o,
   input  flit_t [NumVirtChannels-1:0]                    data_i,
   input  logic  [NumVirtChannels-1:0][NumOutput-1:0]     mask_i,
   input  logic  [NumVirtChannels-1:0]                    last_i,
   output logic  [NumOutput-1:0][NumVirtChannels-1:0]     valid_o,
   input  logic  [NumOutput-1:0][NumVirtChannels-1:0]     ready_i,
   output flit_t [NumOutput-1:0][NumVirtChannels-1:0]     data_o,
   output logic  [NumVirtChannels-1:0]                    err_o
);

   typedef enum logic {
      ST_HEAD = 1'b0,
      ST_BODY = 1'b1
   } state_e;

   state_e                                    r_state     [NumVirtChannels];
   state_e                                    w_state_nxt [NumVirtChannels];
   logic [NumVirtChannels-1:0][NumOutput-1:0] r_lock;
   logic [NumVirtChannels-1:0][NumOutput-1:0] w_lock_nxt;
   logic [NumVirtChannels-1:0][NumOutput-1:0] w_eff_mask;
   logic [NumVirtChannels-1:0][NumOutput-1:0] w_done;
   logic [NumVirtChannels-1:0][NumOutput-1:0] w_rdy_col;
   logic [NumVirtChannels-1:0][NumOutput-1:0] w_vld_col;
   logic [NumVirtChannels-1:0]                w_fire;

   // Transpose between VC-major internal vectors and output-major ports
   for (genvar o = 0; o < NumOutput; o++) begin : g_out
      for (genvar v = 0; v < NumVirtChannels; v++) begin : g_vc
         assign w_rdy_col[v][o] = ready_i[o][v];
         assign valid_o[o][v]   = w_vld_col[v][o];
         assign data_o[o][v]    = data_i[v];
      end
   end

   // Per-VC next state, packet mask lock and fork handshake
   always_comb begin
      w_state_nxt = r_state;
      w_lock_nxt  = r_lock;
      w_eff_mask  = '0;
      w_vld_col   = '0;
      ready_o     = '0;
      w_fire      = '0;
      for (int v = 0; v < NumVirtChannels; v++) begin
         w_eff_mask[v] = (r_state[v] == ST_BODY) ? r_lock[v] : mask_i[v];
         if (AsyncFork) begin
            w_vld_col[v] = {NumOutput{valid_i[v]}} & w_eff_mask[v] & ~w_done[v];
            ready_o[v]   = &(~w_eff_mask[v] | w_done[v] | w_rdy_col[v]);
         end else begin
            ready_o[v]   = &(~w_eff_mask[v] | w_rdy_col[v]);
            w_vld_col[v] = {NumOutput{valid_i[v] & ready_o[v]}} & w_eff_mask[v];
         end
         w_fire[v] = valid_i[v] & ready_o[v];
         case (r_state[v])
            ST_HEAD: begin
               if (w_fire[v] && !last_i[v]) begin
                  w_state_nxt[v] = ST_BODY;
                  w_lock_nxt[v]  = mask_i[v];
               end
            end
            ST_BODY: begin
               if (w_fire[v] && last_i[v]) begin
                  w_state_nxt[v] = ST_HEAD;
               end
            end
            default: w_state_nxt[v] = ST_HEAD;
         endcase
      end
   end

   // FSM state and locked packet mask
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int v = 0; v < NumVirtChannels; v++) begin
            r_state[v] <= ST_HEAD;
         end
         r_lock <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_lock  <= w_lock_nxt;
      end
   end

   if (AsyncFork) begin : g_done
      logic [NumVirtChannels-1:0][NumOutput-1:0] r_done;

      // Outputs that already took the current flit; a fire clears them first
      always_ff @(posedge clk_i) begin
         if (!rst_ni) begin
            r_done <= '0;
         end else begin
            for (int v = 0; v < NumVirtChannels; v++) begin
               if (w_fire[v]) begin
                  r_done[v] <= '0;
               end else begin
                  r_done[v] <= r_done[v] | (w_vld_col[v] & w_rdy_col[v]);
               end
            end
         end
      end

      assign w_done = r_done;
   end else begin : g_no_done
      assign w_done = '0;
   end

`ifdef FLOO_MCAST_FORK_WATCHDOG_EN
   localparam int unsigned WdCntW = $clog2(WatchdogCycles + 1);
   localparam logic [WdCntW-1:0] WdLimit   = WdCntW'(WatchdogCycles);
   localparam logic [WdCntW-1:0] WdPreLim  = WdCntW'(WatchdogCycles - 1);

   logic [NumVirtChannels-1:0][WdCntW-1:0] r_wd_cnt;
   logic [NumVirtChannels-1:0]             r_err;

   // Saturating stall counter per VC with sticky error on reaching the limit
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_wd_cnt <= '0;
         r_err    <= '0;
      end else begin
         for (int v = 0; v < NumVirtChannels; v++) begin
            if (w_fire[v]) begin
               r_wd_cnt[v] <= '0;
            end else if (valid_i[v] && !ready_o[v]) begin
               if (r_wd_cnt[v] != WdLimit) begin
                  r_wd_cnt[v] <= r_wd_cnt[v] + WdCntW'(1);
               end
               if (r_wd_cnt[v] == WdPreLim) begin
                  r_err[v] <= 1'b1;
               end
            end
         end
      end
   end

   assign err_o = r_err;
`else
   assign err_o = '0;
`endif

endmodule

// File: tb/tb_floo_mcast_fork.sv
// Bench for floo_mcast_fork: async and sync instances driven in lock-step by
// directed scenarios and random traffic, checked against a packet-level model.
module tb_floo_mcast_fork;
   localparam int unsigned NO = 5;
   localparam int unsigned NV = 2;
   localparam int unsigned WD = 8;
   typedef logic [7:0] flit_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // index 0 = async instance, index 1 = sync instance
   logic  [NV-1:0]         vin  [2];
   flit_t [NV-1:0]         din  [2];
   logic  [NV-1:0][NO-1:0] min  [2];
   logic  [NV-1:0]         lin  [2];
   logic  [NO-1:0][NV-1:0] rin  [2];
   logic  [NV-1:0]         rdy  [2];
   logic  [NO-1:0][NV-1:0] vo   [2];
   flit_t [NO-1:0][NV-1:0] dout [2];
   logic  [NV-1:0]         err  [2];

   floo_mcast_fork #(
      .NumOutput(NO), .NumVirtChannels(NV), .flit_t(flit_t),
      .AsyncFork(1'b1), .WatchdogCycles(WD)
   ) u_async (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(vin[0]), .ready_o(rdy[0]),
      .data_i(din[0]), .mask_i(min[0]), .last_i(lin[0]), .valid_o(vo[0]),
      .ready_i(rin[0]), .data_o(dout[0]), .err_o(err[0])
   );

   floo_mcast_fork #(
      .NumOutput(NO), .NumVirtChannels(NV), .flit_t(flit_t),
      .AsyncFork(1'b0), .WatchdogCycles(WD)
   ) u_sync (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(vin[1]), .ready_o(rdy[1]),
      .data_i(din[1]), .mask_i(min[1]), .last_i(lin[1]), .valid_o(vo[1]),
      .ready_i(rin[1]), .data_o(dout[1]), .err_o(err[1])
   );

   // Reference model: packet-level view per instance/VC
   bit          m_inpkt [2][NV];   // inside a multi-flit packet
   logic [NO-1:0] m_pmask [2][NV]; // destinations of that packet
   logic [NO-1:0] m_dlv   [2][NV]; // outputs that already own the current flit
   int          m_stall [2][NV];
   bit          m_err   [2][NV];
   bit          m_fired [2][NV];
   logic [NO-1:0] e_vo  [2][NV];
   bit          e_rdy   [2][NV];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NO-1:0] col(input logic [NO-1:0][NV-1:0] x, input int v);
      logic [NO-1:0] r;
      for (int o = 0; o < NO; o++) r[o] = x[o][v];
      return r;
   endfunction

   function automatic bit exp_err(input int m, input int v);
`ifdef FLOO_MCAST_FORK_WATCHDOG_EN
      return m_err[m][v];
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 2; m++)
         for (int v = 0; v < NV; v++) begin
            m_inpkt[m][v] = 0; m_pmask[m][v] = '0; m_dlv[m][v] = '0;
            m_stall[m][v] = 0; m_err[m][v] = 0; m_fired[m][v] = 0;
         end
   endtask

   // Expected outputs: async offers the flit to every owed target and consumes
   // it once none is left waiting; sync offers only when all targets are ready.
   task automatic model_eval();
      logic [NO-1:0] tgt, rc, owed;
      for (int m = 0; m < 2; m++)
         for (int v = 0; v < NV; v++) begin
            tgt = m_inpkt[m][v] ? m_pmask[m][v] : min[m][v];
            rc  = col(rin[m], v);
            if (m == 0) begin
               owed        = tgt & ~m_dlv[m][v];
               e_vo[m][v]  = vin[m][v] ? owed : '0;
               e_rdy[m][v] = ((owed & ~rc) == '0);
            end else begin
               e_rdy[m][v] = ((tgt & ~rc) == '0);
               e_vo[m][v]  = (vin[m][v] && e_rdy[m][v]) ? tgt : '0;
            end
         end
   endtask

   task automatic model_update();
      bit fire;
      if (!rst_n) begin
         model_reset();
         return;
      end
      for (int m = 0; m < 2; m++)
         for (int v = 0; v < NV; v++) begin
            fire = vin[m][v] && e_rdy[m][v];
            m_fired[m][v] = fire;
            if (fire) begin
               m_dlv[m][v]   = '0;
               m_stall[m][v] = 0;
               if (!m_inpkt[m][v] && !lin[m][v]) begin
                  m_inpkt[m][v] = 1;
                  m_pmask[m][v] = min[m][v];
               end else if (m_inpkt[m][v] && lin[m][v]) begin
                  m_inpkt[m][v] = 0;
               end
            end else begin
               m_dlv[m][v] = m_dlv[m][v] | (e_vo[m][v] & col(rin[m], v));
               if (vin[m][v]) begin
                  if (m_stall[m][v] < WD) m_stall[m][v]++;
                  if (m_stall[m][v] >= WD) m_err[m][v] = 1;
               end
            end
         end
   endtask

   task automatic compare_all();
      for (int m = 0; m < 2; m++)
         for (int v = 0; v < NV; v++) begin
            chk($sformatf("m%0d_valid_v%0d", m, v), 64'(col(vo[m], v)), 64'(e_vo[m][v]));
            chk($sformatf("m%0d_ready_v%0d", m, v), 64'(rdy[m][v]), 64'(e_rdy[m][v]));
            chk($sformatf("m%0d_err_v%0d", m, v), 64'(err[m][v]), 64'(exp_err(m, v)));
            for (int o = 0; o < NO; o++)
               chk($sformatf("m%0d_data_o%0d_v%0d", m, o, v), 64'(dout[m][o][v]), 64'(din[m][v]));
         end
   endtask

   task automatic settle();
      #1;
      model_eval();
      compare_all();
   endtask

   task automatic advance();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic clr_in();
      for (int m = 0; m < 2; m++) begin
         vin[m] = '0; din[m] = '0; min[m] = '0; lin[m] = '0; rin[m] = '0;
      end
   endtask

   // Same single-flit stimulus on VC0 of both instances
   task automatic drive_vc0(input logic [NO-1:0] mask, input flit_t d, input bit last);
      for (int m = 0; m < 2; m++) begin
         vin[m][0] = 1'b1; din[m][0] = d; min[m][0] = mask; lin[m][0] = last;
      end
   endtask

   initial begin
      logic [NO-1:0] tmp;
      model_reset();
      clr_in();
      rst_n = 1'b0;
      @(negedge clk);
      advance();
      advance();

      // Reset state: idle outputs, empty mask consumes immediately
      settle();
      for (int m = 0; m < 2; m++) begin
         chk($sformatf("rst_ready_m%0d", m), 64'(rdy[m]), 64'(2'b11));
         chk($sformatf("rst_valid_m%0d", m), 64'(vo[m]), 64'd0);
         chk($sformatf("rst_err_m%0d", m), 64'(err[m]), 64'd0);
      end
      rst_n = 1'b1;
      advance();

      // Partial acceptance: output 1 ready from cycle 0, output 2 in cycle 2
      drive_vc0(5'b00110, 8'hA5, 1'b1);
      for (int m = 0; m < 2; m++) rin[m][1][0] = 1'b1;
      settle();
      chk("async_c0_ready", 64'(rdy[0][0]), 64'd0);
      chk("async_c0_valid", 64'(col(vo[0], 0)), 64'(5'b00110));
      chk("sync_c0_ready", 64'(rdy[1][0]), 64'd0);
      chk("sync_c0_valid", 64'(col(vo[1], 0)), 64'd0);
      advance();
      settle();
      chk("async_c1_ready", 64'(rdy[0][0]), 64'd0);
      chk("async_c1_valid", 64'(col(vo[0], 0)), 64'(5'b00100));
      chk("sync_c1_valid", 64'(col(vo[1], 0)), 64'd0);
      advance();
      for (int m = 0; m < 2; m++) rin[m][2][0] = 1'b1;
      settle();
      chk("async_c2_ready", 64'(rdy[0][0]), 64'd1);
      chk("async_c2_valid", 64'(col(vo[0], 0)), 64'(5'b00100));
      chk("sync_c2_ready", 64'(rdy[1][0]), 64'd1);
      chk("sync_c2_valid", 64'(col(vo[1], 0)), 64'(5'b00110));
      advance();
      clr_in();

      // 3-flit packet on VC1: body masks must be ignored
      for (int k = 0; k < 3; k++) begin
         for (int m = 0; m < 2; m++) begin
            vin[m][1] = 1'b1; din[m][1] = flit_t'(8'h10 + k);
            min[m][1] = (k == 0) ? 5'b01001 : 5'b10000;
            lin[m][1] = (k == 2);
            for (int o = 0; o < NO; o++) rin[m][o][1] = 1'b1;
         end
         settle();
         for (int m = 0; m < 2; m++) begin
            chk($sformatf("pkt_f%0d_valid_m%0d", k, m), 64'(col(vo[m], 1)), 64'(5'b01001));
            chk($sformatf("pkt_f%0d_ready_m%0d", k, m), 64'(rdy[m][1]), 64'd1);
         end
         advance();
      end
      for (int m = 0; m < 2; m++) begin
         min[m][1] = 5'b00010; lin[m][1] = 1'b1;
      end
      settle();
      for (int m = 0; m < 2; m++)
         chk($sformatf("pkt_head_again_m%0d", m), 64'(col(vo[m], 1)), 64'(5'b00010));
      advance();
      clr_in();

      // Empty mask: consumed at once, nothing forwarded
      drive_vc0(5'b00000, 8'h3C, 1'b1);
      settle();
      for (int m = 0; m < 2; m++) begin
         chk($sformatf("empty_ready_m%0d", m), 64'(rdy[m][0]), 64'd1);
         chk($sformatf("empty_valid_m%0d", m), 64'(vo[m]), 64'd0);
      end
      advance();
      clr_in();

      // Watchdog: output 1 stalled
      drive_vc0(5'b00010, 8'h77, 1'b1);
      for (int k = 0; k < 10; k++) begin
         settle();
         for (int m = 0; m < 2; m++)
`ifdef FLOO_MCAST_FORK_WATCHDOG_EN
            chk($sformatf("wd_err_k%0d_m%0d", k, m), 64'(err[m][0]), 64'(k >= 8));
`else
            chk($sformatf("wd_err_k%0d_m%0d", k, m), 64'(err[m][0]), 64'd0);
`endif
         advance();
      end
      for (int m = 0; m < 2; m++) rin[m][1][0] = 1'b1;
      settle();
      advance();
      clr_in();

      // Reset during a partially accepted flit
      drive_vc0(5'b00110, 8'h5A, 1'b1);
      for (int m = 0; m < 2; m++) rin[m][1][0] = 1'b1;
      settle();
      advance();
      for (int m = 0; m < 2; m++) rin[m] = '0;
      rst_n = 1'b0;
      settle();
      chk("rstmid_pre_valid", 64'(col(vo[0], 0)), 64'(5'b00100));
      advance();
      rst_n = 1'b1;
      settle();
      chk("rstmid_post_valid", 64'(col(vo[0], 0)), 64'(5'b00110));
      chk("rstmid_post_err", 64'(err[0]), 64'd0);
      advance();
      clr_in();
      for (int m = 0; m < 2; m++)
         for (int v = 0; v < NV; v++) m_fired[m][v] = 0;

      // Random traffic; a pending flit is held until consumed
      for (int c = 0; c < 400; c++) begin
         for (int m = 0; m < 2; m++)
            for (int v = 0; v < NV; v++) begin
               if (!(vin[m][v] && !m_fired[m][v])) begin
                  vin[m][v] = ($urandom_range(0, 9) < 7);
                  din[m][v] = flit_t'($urandom_range(0, 255));
                  tmp       = NO'($urandom_range(0, 31));
                  if ($urandom_range(0, 9) == 0) tmp = '0;
                  min[m][v] = tmp;
                  lin[m][v] = ($urandom_range(0, 9) < 4);
               end
               for (int o = 0; o < NO; o++)
                  rin[m][o][v] = ($urandom_range(0, 99) < 60);
            end
         settle();
         advance();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
